pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised next-generation fetch program counter. Holds the stage-1a fetch address and chooses the next address by priority: trap, jalr, jump/taken branch, or sequential. On every accepted redirect it drives a multi-cycle wrong-path flush, registers the link address, and flags misaligned targets. It sits at the front of the 7-stage pipe and takes redirect requests resolved in stage 3.

Parameters:
XLEN, 32, address/data width in bits.
BOOT_ADDRESS, `BOOT_ADDRESS, fetch address loaded on reset.
FLUSH_CYCLES, 2, number of unstalled cycles do_flush stays high after a redirect; legal range 1..15.
STEP, 4, sequential increment in bytes.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  freezes all state when high.
valid  input  1  stage-3 instruction is valid; qualifies every redirect request.
jump  input  1  jal or taken branch in stage 3.
jalr  input  1  jalr in stage 3.
s3_instruction_addr  input  XLEN  PC of the stage-3 instruction.
jump_offset  input  XLEN  immediate offset for jump.
jalr_target  input  XLEN  rs1+imm sum for jalr.
s1a_instruction_addr  output  XLEN  current fetch address.
link_addr  output  XLEN  s3_instruction_addr+4 of the last accepted jump/jalr.
do_flush  output  1  kill wrong-path instructions in s1a..s2.
redirect  output  1  one-cycle pulse: a redirect was accepted on the previous edge.
misaligned_fault  output  1  one-cycle pulse: a redirect target was misaligned.

Behaviour:
- Reset values (synchronous, active-high):
  - s1a_instruction_addr = BOOT_ADDRESS.
  - link_addr = 0, do_flush = 0, redirect = 0, misaligned_fault = 0.
  - Flush FSM = IDLE, flush counter = 0.
  - Reset overrides stall and every other input. Reset mid-flush ends the flush immediately.
- Stall high: no register changes at all, including the flush counter and the pulse outputs. Redirect inputs are ignored while stalled; the producer must hold them until stall drops.
- Target selection, combinational, in priority order:
  - trap (feature only).
  - jalr && valid: target = jalr_target with bit 0 forced to 0.
  - jump && valid: target = s3_instruction_addr + jump_offset, modulo 2^XLEN.
  - Otherwise: s1a_instruction_addr + STEP, modulo 2^XLEN; wraps from 0xFFFFFFFC to 0x00000000 with no fault.
- Misalignment:
  - A jump or jalr target with bit 1 set is not taken.
  - The PC advances sequentially, misaligned_fault pulses for one cycle, there is no flush, and link_addr is unchanged.
- Accepted redirect (not stalled, not misaligned):
  - s1a_instruction_addr <= target.
  - link_addr <= s3_instruction_addr + 4 (jump/jalr only).
  - redirect pulses high for one cycle.
  - Flush FSM enters FLUSHING with counter = FLUSH_CYCLES.
- Flush FSM states: IDLE and FLUSHING.
  - do_flush is registered and is high exactly while the FSM is in FLUSHING.
  - In FLUSHING, the counter decrements on each unstalled edge; the FSM returns to IDLE on the edge where the counter reaches 1.
  - A new accepted redirect during FLUSHING reloads the counter to FLUSH_CYCLES.
  - Redirect requests are still honoured during FLUSHING; the stage-3 valid is the owner's responsibility.
- Latency: one edge from redirect request to the new s1a_instruction_addr, redirect pulse, and do_flush.
- jump and jalr both high: jalr wins.

Optional Feature:
Macro PC_GEN_TRAP_EN.
- Defined: adds ports trap (input, 1) and trap_vector (input, XLEN).
  - trap outranks all other sources and does not require valid.
  - Target = trap_vector with bits [1:0] cleared; never faults.
  - Starts a flush and leaves link_addr unchanged.
- Undefined: these ports and their logic are absent; behaviour is exactly as described above.

Test Plan:
- Reset with BOOT_ADDRESS=0x0000_1000, then 3 unstalled cycles: s1a_instruction_addr = 0x1000, 0x1004, 0x1008, 0x100C; do_flush = 0 throughout.
- valid=1, jump=1, s3_instruction_addr=0x2000, jump_offset=0x40: next edge gives s1a_instruction_addr=0x2040, link_addr=0x2004, redirect=1; do_flush=1 for exactly 2 cycles, then 0.
- valid=1, jalr=1, jump=1, jalr_target=0x3001: s1a_instruction_addr=0x3000 (jalr wins, bit 0 cleared). Repeat with jalr_target=0x3002: misaligned_fault pulses, PC advances +4, do_flush stays 0.
- Hold stall=1 for 3 cycles during FLUSHING with counter=2, with jump requested: PC, do_flush and counter are all frozen and the jump is not taken; after release the flush finishes its 2 unstalled cycles.
- Second jump accepted 1 cycle into a flush: counter reloads, do_flush stays high for 2 further cycles. Assert reset mid-flush: do_flush=0 and s1a_instruction_addr=BOOT_ADDRESS on the next edge.
- With PC_GEN_TRAP_EN defined: trap=1, trap_vector=0x8003, jalr=1, valid=1: s1a_instruction_addr=0x8000, flush starts, link_addr unchanged.

Source files
------------

// File: rtl/pc_gen.sv
// Purpose : fetch program counter; picks next s1a address (trap > jalr > jump/branch > sequential)
//           and drives the wrong-path flush, link address and misaligned-target pulse.
// Latency : 1 edge from a stage-3 redirect request to new PC, redirect pulse and do_flush.
// Backpressure: stall freezes every register; redirect requesters must hold their inputs until stall drops.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   stall                     freeze all state
//   valid, jump, jalr         stage-3 redirect request qualifiers
//   s3_instruction_addr       PC of the stage-3 instruction
//   jump_offset, jalr_target  jump immediate / jalr rs1+imm sum
//   s1a_instruction_addr      current fetch address
//   link_addr                 s3_instruction_addr+4 of the last accepted jump/jalr
//   do_flush                  kill wrong-path instructions in s1a..s2
//   redirect                  1-cycle pulse after an accepted redirect
//   misaligned_fault          1-cycle pulse after a rejected misaligned jump/jalr target
// Optional feature macro PC_GEN_TRAP_EN adds trap / trap_vector (highest priority, no valid needed).

`ifndef BOOT_ADDRESS
`define BOOT_ADDRESS 32'h0000_1000
`endif

module pc_gen #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   BOOT_ADDRESS = `BOOT_ADDRESS,
   parameter int unsigned       FLUSH_CYCLES = 2,
   parameter int unsigned       STEP         = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            stall,
   input  logic            valid,
   input  logic            jump,
   input  logic            jalr,
   input  logic [XLEN-1:0] s3_instruction_addr,
   input  logic [XLEN-1:0] jump_offset,
   input  logic [XLEN-1:0] jalr_target,
`ifdef PC_GEN_TRAP_EN
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vector,
`endif
   output logic [XLEN-1:0] s1a_instruction_addr,
   output logic [XLEN-1:0] link_addr,
   output logic            do_flush,
   output logic            redirect,
   output logic            misaligned_fault
);

   typedef enum logic {IDLE, FLUSHING} flush_state_t;

   flush_state_t    state_q, state_d;
   logic [3:0]      count_q, count_d;
   logic [XLEN-1:0] pc_q, link_q;
   logic            flush_q, redirect_q, fault_q;

   logic [XLEN-1:0] seq_pc, target, next_pc;
   logic            take_req, is_trap, misaligned, accept;

   assign seq_pc = pc_q + XLEN'(STEP);

   // Target selection in priority order. take_req marks a non-sequential request.
   always_comb begin
      target   = seq_pc;
      take_req = 1'b0;
      is_trap  = 1'b0;
`ifdef PC_GEN_TRAP_EN
      if (trap) begin
         target   = trap_vector & ~XLEN'(3);
         take_req = 1'b1;
         is_trap  = 1'b1;
      end else
`endif
      if (valid && jalr) begin
         target   = jalr_target & ~XLEN'(1);
         take_req = 1'b1;
      end else if (valid && jump) begin
         target   = s3_instruction_addr + jump_offset;
         take_req = 1'b1;
      end
   end

   // A jump/jalr target with bit 1 set is dropped; fetch simply continues sequentially.
   assign misaligned = take_req && !is_trap && target[1];
   assign accept     = take_req && !misaligned;
   assign next_pc    = accept ? target : seq_pc;

   // Flush FSM next state: any accepted redirect (re)loads the counter.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (accept) begin
         state_d = FLUSHING;
         count_d = 4'(FLUSH_CYCLES);
      end else if (state_q == FLUSHING) begin
         if (count_q == 4'd1) begin
            state_d = IDLE;
            count_d = 4'd0;
         end else begin
            count_d = count_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= BOOT_ADDRESS;
         link_q     <= '0;
         state_q    <= IDLE;
         count_q    <= 4'd0;
         flush_q    <= 1'b0;
         redirect_q <= 1'b0;
         fault_q    <= 1'b0;
      end else if (!stall) begin
         pc_q       <= next_pc;
         if (accept && !is_trap) begin
            link_q <= s3_instruction_addr + XLEN'(4);
         end
         state_q    <= state_d;
         count_q    <= count_d;
         // Registered copy of the FSM state so do_flush is a clean flop output.
         flush_q    <= (state_d == FLUSHING);
         redirect_q <= accept;
         fault_q    <= misaligned;
      end
   end

   assign s1a_instruction_addr = pc_q;
   assign link_addr            = link_q;
   assign do_flush             = flush_q;
   assign redirect             = redirect_q;
   assign misaligned_fault     = fault_q;

endmodule

// File: tb/tb_pc_gen.sv
// Purpose : self-checking bench for pc_gen: directed per-cycle vector table, then random traffic
//           against a behavioural model that tracks the flush as "cycles remaining".
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: stall is exercised both in the table and randomly.

module tb_pc_gen;

   localparam logic [31:0] BOOT = 32'h0000_1000;
   localparam int          FC   = 2;

   logic        clock;
   logic        reset, stall, valid, jump, jalr;
   logic [31:0] s3_instruction_addr, jump_offset, jalr_target;
   logic        trap;
   logic [31:0] trap_vector;
   logic [31:0] s1a_instruction_addr, link_addr;
   logic        do_flush, redirect, misaligned_fault;

   int n_cmp = 0;
   int n_bad = 0;

   pc_gen #(.XLEN(32), .BOOT_ADDRESS(BOOT), .FLUSH_CYCLES(FC), .STEP(4)) dut (
      .clock               (clock),
      .reset               (reset),
      .stall               (stall),
      .valid               (valid),
      .jump                (jump),
      .jalr                (jalr),
      .s3_instruction_addr (s3_instruction_addr),
      .jump_offset         (jump_offset),
      .jalr_target         (jalr_target),
`ifdef PC_GEN_TRAP_EN
      .trap                (trap),
      .trap_vector         (trap_vector),
`endif
      .s1a_instruction_addr(s1a_instruction_addr),
      .link_addr           (link_addr),
      .do_flush            (do_flush),
      .redirect            (redirect),
      .misaligned_fault    (misaligned_fault)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        rst, stl, vld, jmp, jlr;
      logic [31:0] s3, off, jt;
      logic [31:0] e_pc, e_link;
      logic        e_fl, e_rd, e_ft;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, stl, vld, jmp, jlr,
                      input logic [31:0] s3, off, jt, e_pc, e_link,
                      input logic e_fl, e_rd, e_ft);
      vec_t v;
      v.rst = rst; v.stl = stl; v.vld = vld; v.jmp = jmp; v.jlr = jlr;
      v.s3 = s3; v.off = off; v.jt = jt; v.e_pc = e_pc; v.e_link = e_link;
      v.e_fl = e_fl; v.e_rd = e_rd; v.e_ft = e_ft;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, e_link,
                            input logic e_fl, e_rd, e_ft);
      chk({tag, " pc"},    s1a_instruction_addr, e_pc);
      chk({tag, " link"},  link_addr, e_link);
      chk({tag, " flush"}, {31'd0, do_flush}, {31'd0, e_fl});
      chk({tag, " redir"}, {31'd0, redirect}, {31'd0, e_rd});
      chk({tag, " fault"}, {31'd0, misaligned_fault}, {31'd0, e_ft});
   endtask

   // Behavioural reference: PC, link, cycles of flush remaining, last-cycle pulses.
   logic [31:0] m_pc, m_link;
   int          m_rem;
   logic        m_rd, m_ft;

   task automatic model_edge();
      logic        req, tr;
      logic [31:0] tgt;
      if (reset) begin
         m_pc = BOOT; m_link = 0; m_rem = 0; m_rd = 0; m_ft = 0;
      end else if (!stall) begin
         tr  = trap;
         req = tr || (valid && (jalr || jump));
         if (tr)         tgt = {trap_vector[31:2], 2'b00};
         else if (jalr)  tgt = {jalr_target[31:1], 1'b0};
         else            tgt = s3_instruction_addr + jump_offset;
         m_rem = (m_rem > 0) ? m_rem - 1 : 0;
         m_rd  = 0;
         m_ft  = 0;
         if (req && !tr && tgt[1]) begin
            m_ft = 1;
            m_pc = m_pc + 4;
         end else if (req) begin
            m_pc  = tgt;
            m_rd  = 1;
            m_rem = FC;
            if (!tr) m_link = s3_instruction_addr + 4;
         end else begin
            m_pc = m_pc + 4;
         end
      end
   endtask

   initial begin
      reset = 1; stall = 0; valid = 0; jump = 0; jalr = 0;
      s3_instruction_addr = 0; jump_offset = 0; jalr_target = 0;
      trap = 0; trap_vector = 0;

      //   rst stl vld jmp jlr  s3            off           jt            e_pc          e_link       fl rd ft
      add(1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h1000,     32'h0,        0, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h1004,     32'h0,        0, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h1008,     32'h0,        0, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h100C,     32'h0,        0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h2000,      32'h40,       32'h0,        32'h2040,     32'h2004,     1, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h2044,     32'h2004,     1, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h2048,     32'h2004,     0, 0, 0);
      add(0, 0, 1, 1, 1, 32'h2100,      32'h40,       32'h3001,     32'h3000,     32'h2104,     1, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h3004,     32'h2104,     1, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h3008,     32'h2104,     0, 0, 0);
      add(0, 0, 1, 1, 1, 32'h2100,      32'h40,       32'h3002,     32'h300C,     32'h2104,     0, 0, 1);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h3010,     32'h2104,     0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h4000,      32'hFFFF_FFF8, 32'h0,       32'h3FF8,     32'h4004,     1, 1, 0);
      add(0, 1, 1, 1, 0, 32'h5000,      32'h0,        32'h0,        32'h3FF8,     32'h4004,     1, 1, 0);
      add(0, 1, 1, 1, 0, 32'h5000,      32'h0,        32'h0,        32'h3FF8,     32'h4004,     1, 1, 0);
      add(0, 1, 1, 1, 0, 32'h5000,      32'h0,        32'h0,        32'h3FF8,     32'h4004,     1, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h3FFC,     32'h4004,     1, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h4000,     32'h4004,     0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h6000,      32'h10,       32'h0,        32'h6010,     32'h6004,     1, 1, 0);
      add(0, 0, 1, 1, 0, 32'h7000,      32'h20,       32'h0,        32'h7020,     32'h7004,     1, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h7024,     32'h7004,     1, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h7028,     32'h7004,     0, 0, 0);
      add(0, 0, 1, 1, 0, 32'h8000,      32'h0,        32'h0,        32'h8000,     32'h8004,     1, 1, 0);
      add(1, 1, 1, 1, 0, 32'h9000,      32'h0,        32'h0,        32'h1000,     32'h0,        0, 0, 0);
      add(0, 0, 0, 1, 1, 32'h9000,      32'h0,        32'h9000,     32'h1004,     32'h0,        0, 0, 0);
      add(0, 0, 1, 0, 1, 32'h0,         32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4,      1, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h4,        1, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h4,        32'h4,        0, 0, 0);
      add(0, 0, 1, 1, 0, 32'hFFFF_FFF0, 32'h20,       32'h0,        32'h10,       32'hFFFF_FFF4, 1, 1, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; stall = tbl[i].stl; valid = tbl[i].vld;
         jump = tbl[i].jmp; jalr = tbl[i].jlr;
         s3_instruction_addr = tbl[i].s3; jump_offset = tbl[i].off; jalr_target = tbl[i].jt;
         @(posedge clock); #1;
         check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_link,
                   tbl[i].e_fl, tbl[i].e_rd, tbl[i].e_ft);
      end

`ifdef PC_GEN_TRAP_EN
      // Trap outranks a valid jalr, clears bits [1:0], keeps link, starts a flush.
      reset = 0; stall = 0; valid = 1; jalr = 1; jump = 0;
      jalr_target = 32'h9000; trap = 1; trap_vector = 32'h8003;
      @(posedge clock); #1;
      check_all("trap", 32'h8000, 32'hFFFF_FFF4, 1, 1, 0);
      trap = 0; valid = 0; jalr = 0;
      @(posedge clock); #1;
      check_all("trap+1", 32'h8004, 32'hFFFF_FFF4, 1, 0, 0);
      @(posedge clock); #1;
      check_all("trap+2", 32'h8008, 32'hFFFF_FFF4, 0, 0, 0);
`endif

      // Random traffic against the behavioural model, starting from reset.
      for (int i = 0; i < 2000; i++) begin
         reset = (i == 0) || ($urandom_range(0, 63) == 0);
         stall = ($urandom_range(0, 4) == 0);
         valid = $urandom_range(0, 1);
         jump  = ($urandom_range(0, 2) == 0);
         jalr  = ($urandom_range(0, 3) == 0);
         s3_instruction_addr = $urandom & ~32'h3;
         jump_offset = $urandom;
         if ($urandom_range(0, 3) != 0) jump_offset[1:0] = 2'b00;
         jalr_target = $urandom;
         if ($urandom_range(0, 3) != 0) jalr_target[1] = 1'b0;
`ifdef PC_GEN_TRAP_EN
         trap        = ($urandom_range(0, 15) == 0);
         trap_vector = $urandom;
`endif
         model_edge();
         @(posedge clock); #1;
         check_all($sformatf("rnd%0d", i), m_pc, m_link, (m_rem > 0), m_rd, m_ft);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
